cpu_phase_ctrl: RTL and testbench

//  Instruction-cycle controller for the 8-bit RISC core. Runs an 8-phase cycle per

---
 rtl/cpu_phase_ctrl.sv | 124 ++++++++++++
 tb/tb_cpu_phase_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_phase_ctrl.sv
// Eight-phase instruction-cycle controller for the 8-bit RISC core.
// Moore decode from phase/latched opcode; strobes are masked while ena is low so a stall never repeats an action.
module cpu_phase_ctrl #(
  parameter int OP_W    = 3,
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               wr,
  output logic               ld_ir,
  output logic               ld_ac,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               data_e,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

  // HALTED keeps low bits 4 so the debug phase shows where the halt was taken.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd12
  } state_t;

  state_t          state;
  logic [OP_W-1:0] op_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INST_ADDR;
      op_r  <= '0;
    end else if (ena && state != S_HALTED) begin
      if (state == S_IDLE)
        op_r <= opcode;
      if (state == S_OP_ADDR && op_r == OP_HLT)
        state <= S_HALTED;
      else
        state <= state_t'({1'b0, state[2:0] + 3'd1});
    end
  end

  logic is_alu, is_skz, is_sto, is_jmp, is_hlt;
  assign is_alu = (op_r == OP_ADD) || (op_r == OP_AND) || (op_r == OP_XOR) || (op_r == OP_LDA);
  assign is_skz = (op_r == OP_SKZ);
  assign is_sto = (op_r == OP_STO);
  assign is_jmp = (op_r == OP_JMP);
  assign is_hlt = (op_r == OP_HLT);

  logic wr_raw, ld_ir_raw, ld_ac_raw, inc_pc_raw, ld_pc_raw;

  always_comb begin
    sel        = 1'b0;
    rd         = 1'b0;
    data_e     = 1'b0;
    halt       = 1'b0;
    wr_raw     = 1'b0;
    ld_ir_raw  = 1'b0;
    ld_ac_raw  = 1'b0;
    inc_pc_raw = 1'b0;
    ld_pc_raw  = 1'b0;
    case (state)
      S_INST_ADDR:  sel = 1'b1;
      S_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        sel       = 1'b1;
        rd        = 1'b1;
        ld_ir_raw = 1'b1;
      end
      S_OP_ADDR: begin
        inc_pc_raw = 1'b1;
        halt       = is_hlt;
      end
      S_OP_FETCH: rd = is_alu;
      S_ALU_OP: begin
        rd         = is_alu;
        inc_pc_raw = is_skz && zero;
        ld_pc_raw  = is_jmp;
        data_e     = is_sto;
      end
      S_STORE: begin
        rd         = is_alu;
        ld_ac_raw  = is_alu;
        inc_pc_raw = is_skz && zero;
        ld_pc_raw  = is_jmp;
        wr_raw     = is_sto;
        data_e     = is_sto;
      end
      S_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  assign wr     = wr_raw     & ena;
  assign ld_ir  = ld_ir_raw  & ena;
  assign ld_ac  = ld_ac_raw  & ena;
  assign inc_pc = inc_pc_raw & ena;
  assign ld_pc  = ld_pc_raw  & ena;
  assign phase  = state[PHASE_W-1:0];

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Directed bench for cpu_phase_ctrl: per-phase output vectors compared against hand-written tables.
module tb_cpu_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst, ena, zero;
  logic [2:0] opcode;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  logic [2:0] phase;
  logic [8:0] outv;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_phase_ctrl #(.OP_W(3), .PHASE_W(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .data_e(data_e), .halt(halt), .phase(phase)
  );

  // Bit order: sel rd wr ld_ir ld_ac inc_pc ld_pc data_e halt
  assign outv = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};

  localparam logic [8:0] F0   = 9'b100000000;
  localparam logic [8:0] F1   = 9'b110000000;
  localparam logic [8:0] F23  = 9'b110100000;
  localparam logic [8:0] P4N  = 9'b000001000;
  localparam logic [8:0] P4H  = 9'b000001001;
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] HLTD = 9'b000000001;

  localparam logic [7:0][8:0] E_LDA  = {9'b010010000, 9'b010000000, 9'b010000000, P4N, F23, F23, F1, F0};
  localparam logic [7:0][8:0] E_STO  = {9'b001000010, 9'b000000010, NONE, P4N, F23, F23, F1, F0};
  localparam logic [7:0][8:0] E_SKZ1 = {P4N, P4N, NONE, P4N, F23, F23, F1, F0};
  localparam logic [7:0][8:0] E_SKZ0 = {NONE, NONE, NONE, P4N, F23, F23, F1, F0};
  localparam logic [7:0][8:0] E_JMP  = {9'b000000100, 9'b000000100, NONE, P4N, F23, F23, F1, F0};
  localparam logic [7:0][8:0] E_HLT  = {NONE, NONE, NONE, P4H, F23, F23, F1, F0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [8:0] exp_v);
    n_assert++;
    assert (outv === exp_v) else begin
      n_fail++;
      $error("FAIL %s outputs: got %b expected %b", tag, outv, exp_v);
    end
  endtask

  task automatic check(input string tag, input logic [2:0] exp_ph, input logic [8:0] exp_v);
    n_assert++;
    assert (phase === exp_ph) else begin
      n_fail++;
      $error("FAIL %s phase: got %0d expected %0d", tag, phase, exp_ph);
    end
    check_vec(tag, exp_v);
  endtask

  task automatic run_instr(input string tag, input logic [7:0][8:0] exp, input int n_ph);
    for (int p = 0; p < n_ph; p++) begin
      #2 check($sformatf("%s p%0d", tag, p), p[2:0], exp[p]);
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_assert++;
      assert (!(inc_pc === 1'b1 && ld_pc === 1'b1)) else begin
        n_fail++;
        $error("FAIL inc_ld_excl: inc_pc=%b ld_pc=%b expected not both 1", inc_pc, ld_pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; opcode = 3'd0; zero = 1'b0;
    repeat (2) tick();
    #2 check("reset", 3'd0, F0);

    rst = 1'b0; ena = 1'b1; opcode = 3'd5;
    run_instr("lda", E_LDA, 8);

    opcode = 3'd6;
    run_instr("sto", E_STO, 8);

    opcode = 3'd1; zero = 1'b1;
    run_instr("skz_z1", E_SKZ1, 8);
    zero = 1'b0;
    run_instr("skz_z0", E_SKZ0, 8);

    opcode = 3'd7; zero = 1'b1;
    run_instr("jmp", E_JMP, 8);
    zero = 1'b0;

    // Stall in phase 7 of a store, then release for a single write.
    opcode = 3'd6;
    run_instr("sto_st", E_STO, 7);
    ena = 1'b0;
    repeat (5) begin
      #2 check("stall p7", 3'd7, 9'b000000010);
      tick();
    end
    ena = 1'b1;
    #2 check("stall release", 3'd7, 9'b001000010);
    tick();
    #2 check("after store", 3'd0, F0);

    // Reset taken mid-instruction.
    opcode = 3'd5;
    run_instr("lda_rst", E_LDA, 5);
    rst = 1'b1;
    #2 check("pre-reset p5", 3'd5, 9'b010000000);
    tick();
    rst = 1'b0;
    #2 check("reset from p5", 3'd0, F0);

    opcode = 3'd0;
    run_instr("hlt", E_HLT, 5);
    for (int i = 0; i < 20; i++) begin
      ena = ~ena;
      #2 check_vec($sformatf("halted c%0d", i), HLTD);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; ena = 1'b1; opcode = 3'd5;
    #2 check("reset from halted", 3'd0, F0);
    run_instr("lda_after", E_LDA, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
